// File: rtl/instruction_memory_bank_if.sv
// Access bus between the fetch stage / program loader (master) and the
// instruction memory bank (slave).
//   en       : access request, sampled only while ready=1
//   wen      : 1=write, 0=read
//   byte_en  : per-byte write lane enable (ignored on reads)
//   addr     : byte address
//   data_in  : write data
//   data_out : read data, zero unless rd_valid
//   rd_valid : one-cycle strobe per completed read (faulted reads included)
//   fault    : one-cycle strobe per misaligned / out-of-range access
//   ready    : high once the post-reset clear sequence has finished
interface instruction_memory_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    en;
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    rd_valid;
    logic                    fault;
    logic                    ready;

    modport master (
        output en, wen, byte_en, addr, data_in,
        input  data_out, rd_valid, fault, ready
    );

    modport slave (
        input  en, wen, byte_en, addr, data_in,
        output data_out, rd_valid, fault, ready
    );
endinterface

// File: rtl/instruction_memory_bank.sv
// Synchronous single-port instruction memory with byte-lane writes, a
// hardware clear sequencer after reset, and a fixed-latency read pipeline
// that also reports faulted accesses.
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : instruction_memory_bank_if slave modport (see interface file)
// Parameters:
//   DATA_WIDTH   : word width, multiple of 8, >= 8
//   ADDR_WIDTH   : byte address width
//   DEPTH        : number of words, power of two, >= 2
//   READ_LATENCY : 1 or 2 cycles from accepting edge to rd_valid
module instruction_memory_bank #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instruction_memory_bank_if.slave    bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        clr_ptr_r;
    logic                    ready_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_addr_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    misalign_s;
    logic                    oor_s;
    logic                    fault_s;
    logic                    accept_s;
    logic                    good_rd_s;
    logic                    good_wr_s;

    logic                    mem_we_s;
    logic [IDX_W-1:0]        mem_widx_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [BYTES-1:0]        mem_wbe_s;

    // Slot 0 is loaded on the accepting edge; the last slot feeds the outputs.
    logic [READ_LATENCY-1:0] pl_vld_r;
    logic [READ_LATENCY-1:0] pl_flt_r;
    logic [DATA_WIDTH-1:0]   pl_data_r [READ_LATENCY];

    logic [DATA_WIDTH-1:0]   data_out_r;
    logic                    rd_valid_r;
    logic                    fault_r;

    // Address decode. The mask form of the alignment check degenerates to
    // "never misaligned" for byte-wide words; out-of-range compares the full
    // word address so high address bits cannot alias into the array.
    always_comb begin
        word_addr_s = bus.addr >> LSB;
        idx_s       = word_addr_s[IDX_W-1:0];
        misalign_s  = (bus.addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}};
        oor_s       = word_addr_s >= DEPTH_A;
        fault_s     = misalign_s | oor_s;
        // ready_r is high exactly in RUN, so requests in CLEAR are dropped.
        accept_s    = ready_r & bus.en;
        good_rd_s   = accept_s & ~bus.wen & ~fault_s;
        good_wr_s   = accept_s &  bus.wen & ~fault_s;
    end

    // Memory write port mux: clear sequencer in CLEAR, loader writes in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_widx_s  = {IDX_W{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        mem_wbe_s   = {BYTES{1'b0}};
        if (!rst_n) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = clr_ptr_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
            mem_wbe_s   = {BYTES{1'b1}};
        end else if (good_wr_s) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = idx_s;
            mem_wdata_s = bus.data_in;
            mem_wbe_s   = bus.byte_en;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; no reset so it maps onto RAM, contents zeroed by CLEAR.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (mem_wbe_s[k]) begin
                    mem_r[mem_widx_s][8*k +: 8] <= mem_wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Clear/run sequencer; ready rises on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {IDX_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + IDX_W'(1);
                    if (clr_ptr_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= {IDX_W{1'b0}};
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Response pipeline. Every accepted read yields a response (faulted reads
    // carry zero data) so the fetch stage never waits; writes only report faults.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pl_vld_r <= {READ_LATENCY{1'b0}};
            pl_flt_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                pl_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            pl_vld_r[0]  <= accept_s & ~bus.wen;
            pl_flt_r[0]  <= accept_s & fault_s;
            pl_data_r[0] <= good_rd_s ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};
            for (int i = 1; i < READ_LATENCY; i++) begin
                pl_vld_r[i]  <= pl_vld_r[i-1];
                pl_flt_r[i]  <= pl_flt_r[i-1];
                pl_data_r[i] <= pl_data_r[i-1];
            end
        end
    end

    // Registered outputs, taken from the last pipeline slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            data_out_r <= pl_data_r[READ_LATENCY-1];
            rd_valid_r <= pl_vld_r[READ_LATENCY-1];
            fault_r    <= pl_flt_r[READ_LATENCY-1];
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.fault    = fault_r;
    assign bus.ready    = ready_r;
endmodule
